// File: rtl/core_sequencer.sv
// Program sequencer for the ROM-driven BCD adder: steps a PC on tick/step, waits out ROM latency,
// issues each word with valid/ready. Optional breakpoint support under `SEQ_BREAKPOINT_EN.
module core_sequencer #(
  parameter int ADDR_W    = 4,
  parameter int LAST_ADDR = 15,
  parameter int ROM_LAT   = 1,
  parameter int LOOP      = 1
) (
  input  logic              CLK_50,
  input  logic              RST_N,
  input  logic              tick,
  input  logic              run,
  input  logic              step,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [16:0]       rom_data,
  output logic [1:0]        alu_op,
  output logic [14:0]       alu_arg,
  output logic              alu_valid,
  input  logic              alu_ready,
  output logic              busy,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_dbg
`ifdef SEQ_BREAKPOINT_EN
  ,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  output logic              bp_hit
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_ISSUE, S_HALT} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);
  localparam logic [1:0]        LAT  = 2'(ROM_LAT);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_dbg_q, pc_dbg_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [14:0]       arg_q, arg_d;
  logic              trig;

`ifdef SEQ_BREAKPOINT_EN
  logic bp_stop, bp_hit_q, bp_hit_d;
  // While parked on the breakpoint only an explicit step may advance.
  assign bp_stop  = run & bp_en & (pc_q == bp_addr);
  assign trig     = run ? (bp_stop ? step : tick) : step;
  assign bp_hit_d = (state_d == S_IDLE) & run & bp_en & (pc_d == bp_addr);
  assign bp_hit   = bp_hit_q;
  always_ff @(posedge CLK_50 or negedge RST_N)
    if (!RST_N) bp_hit_q <= 1'b0;
    else        bp_hit_q <= bp_hit_d;
`else
  assign trig = run ? tick : step;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_dbg_d = pc_dbg_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    arg_d    = arg_q;
    case (state_q)
      S_IDLE:  if (trig) state_d = S_FETCH;
      S_FETCH: begin
        cnt_d   = LAT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 2'd1;
        // rom_data is captured once here; later ROM changes cannot disturb the issue.
        if (cnt_q <= 2'd1) begin
          op_d    = rom_data[16:15];
          arg_d   = rom_data[14:0];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: if (alu_ready) begin
        pc_dbg_d = pc_q;
        if (pc_q == LAST) begin
          if (LOOP != 0) begin
            pc_d    = '0;
            state_d = S_IDLE;
          end else begin
            state_d = S_HALT;
          end
        end else begin
          pc_d    = pc_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      pc_dbg_q <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      arg_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_dbg_q <= pc_dbg_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      arg_q    <= arg_d;
    end
  end

  assign rom_addr  = pc_q;
  assign alu_op    = op_q;
  assign alu_arg   = arg_q;
  assign pc_dbg    = pc_dbg_q;
  assign alu_valid = (state_q == S_ISSUE);
  assign halted    = (state_q == S_HALT);
  assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);

endmodule
